// File: rtl/uart_report_tx.sv
// Serial transmitter for the 16-byte end-of-shower report "ML=dddd T=m:ss\r\n" (8N1; PARITY_EN adds an even parity bit).
// Tx falls one clock after an accepted send; send is ignored (never queued) while busy, and done pulses in the final stop-bit cycle.
module uart_report_tx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        send,
    input  logic [15:0] ml_bcd,
    input  logic [11:0] time_bcd,
    output logic        Tx,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_nxt;
    logic [3:0]       byte_idx;
    logic [3:0]       next_idx;
    logic [15:0]      ml_lat;
    logic [11:0]      time_lat;
    logic [7:0]       shift_dat;
    logic [7:0]       next_byte;
    logic             baud_wrap;

    function automatic logic [7:0] bcd_ascii(input logic [3:0] nib);
        return (nib <= 4'd9) ? {4'h3, nib} : 8'h3F;
    endfunction

    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign bit_nxt   = bit_cnt + 3'd1;
    assign next_idx  = byte_idx + 4'd1;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_STOP) && baud_wrap && (byte_idx == 4'd15);

    // Byte 0 ('M') is loaded directly at accept, so only the following byte is ever looked up.
    always_comb begin
        next_byte = 8'h0A;
        case (next_idx)
            4'd0:    next_byte = 8'h4D;
            4'd1:    next_byte = 8'h4C;
            4'd2:    next_byte = 8'h3D;
            4'd3:    next_byte = bcd_ascii(ml_lat[15:12]);
            4'd4:    next_byte = bcd_ascii(ml_lat[11:8]);
            4'd5:    next_byte = bcd_ascii(ml_lat[7:4]);
            4'd6:    next_byte = bcd_ascii(ml_lat[3:0]);
            4'd7:    next_byte = 8'h20;
            4'd8:    next_byte = 8'h54;
            4'd9:    next_byte = 8'h3D;
            4'd10:   next_byte = bcd_ascii(time_lat[11:8]);
            4'd11:   next_byte = 8'h3A;
            4'd12:   next_byte = bcd_ascii(time_lat[7:4]);
            4'd13:   next_byte = bcd_ascii(time_lat[3:0]);
            4'd14:   next_byte = 8'h0D;
            default: next_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            ml_lat    <= '0;
            time_lat  <= '0;
            shift_dat <= '0;
            Tx        <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (send) begin
                        ml_lat    <= ml_bcd;
                        time_lat  <= time_bcd;
                        byte_idx  <= '0;
                        shift_dat <= 8'h4D;
                        state     <= ST_START;
                        Tx        <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_DATA;
                        Tx       <= shift_dat[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef PARITY_EN
                            state <= ST_PARITY;
                            Tx    <= ^shift_dat;
`else
                            state <= ST_STOP;
                            Tx    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_nxt;
                            Tx      <= shift_dat[bit_nxt];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef PARITY_EN
                ST_PARITY: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                        Tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (byte_idx == 4'd15) begin
                            state <= ST_IDLE;
                            Tx    <= 1'b1;
                        end else begin
                            byte_idx  <= next_idx;
                            shift_dat <= next_byte;
                            state     <= ST_START;
                            Tx        <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    Tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_report_tx.sv
// Scoreboarded bench for uart_report_tx: a cycle-counting serial decoder pops expected report bytes.
module tb_uart_report_tx;

    localparam int CPB = 10;
`ifdef PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = 16 * NBITS * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        send;
    logic [15:0] ml_bcd;
    logic [11:0] time_bcd;
    logic        tx;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    bit       rx_active = 1'b0;
    int       rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;

    uart_report_tx #(
        .CLK_HZ(1_000_000),
        .BAUD(100_000)
    ) dut (
        .Clk(clk),
        .reset(reset),
        .send(send),
        .ml_bcd(ml_bcd),
        .time_bcd(time_bcd),
        .Tx(tx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [15:0] ml, input logic [11:0] tm);
        string hx;
        hx = "0123456789??????";
        exp_q.push_back("M");
        exp_q.push_back("L");
        exp_q.push_back("=");
        exp_q.push_back(hx[ml[15:12]]);
        exp_q.push_back(hx[ml[11:8]]);
        exp_q.push_back(hx[ml[7:4]]);
        exp_q.push_back(hx[ml[3:0]]);
        exp_q.push_back(" ");
        exp_q.push_back("T");
        exp_q.push_back("=");
        exp_q.push_back(hx[tm[11:8]]);
        exp_q.push_back(":");
        exp_q.push_back(hx[tm[7:4]]);
        exp_q.push_back(hx[tm[3:0]]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Serial decoder: start seen at the first low sample, every bit sampled mid-period.
    always @(negedge clk) begin
        if (reset) begin
            rx_active = 1'b0;
            exp_q.delete();
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_byte   = 8'h00;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == CPB / 2) begin
                check("rx_start", tx, 1'b0);
            end else if (rx_cnt > CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2) begin
                rx_byte = {tx, rx_byte[7:1]};
`ifdef PARITY_EN
            end else if (rx_cnt == 9 * CPB + CPB / 2) begin
                check("rx_parity", tx, ^rx_byte);
`endif
            end else if (rx_cnt == (NBITS - 1) * CPB + CPB / 2) begin
                check("rx_stop", tx, 1'b1);
                check("rx_have_exp", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("rx_byte", rx_byte, exp_q.pop_front());
                rx_active = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at a negedge once idle (or after idle_len quiet cycles).
    task automatic run_frame(input logic [15:0] ml, input logic [11:0] tm,
                             input int resend_at, input logic [15:0] ml2, input int idle_len);
        int  bcnt;
        int  dcnt;
        int  done_at;
        int  bad;
        bit  fell;
        push_frame(ml, tm);
        ml_bcd   = ml;
        time_bcd = tm;
        send     = 1'b1;
        @(negedge clk);
        bcnt = 0; dcnt = 0; done_at = 0; fell = 1'b0;
        for (int i = 0; i < 4000 && !fell; i++) begin
            if (busy) bcnt++;
            else fell = 1'b1;
            if (done) begin
                dcnt++;
                done_at = bcnt;
            end
            if (i == resend_at) begin
                ml_bcd = ml2;
                send   = 1'b1;
            end else begin
                send = 1'b0;
            end
            if (!fell) @(negedge clk);
        end
        send = 1'b0;
        check("busy_len", bcnt, FRAME);
        check("done_count", dcnt, 1);
        check("done_pos", done_at, FRAME);
        check("frame_bytes_left", exp_q.size(), 0);
        if (idle_len > 0) begin
            bad = 0;
            repeat (idle_len) begin
                @(negedge clk);
                if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) bad++;
            end
            check("post_idle", bad, 0);
        end
    endtask

    initial begin
        int bad;
        reset    = 1'b1;
        send     = 1'b0;
        ml_bcd   = 16'h0000;
        time_bcd = 12'h000;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;

        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle_500", bad, 0);

        run_frame(16'h1234, 12'h259, -1, 16'h0000, 50);
        run_frame(16'h0A9F, 12'h300, -1, 16'h0000, 50);
        run_frame(16'h5678, 12'h012, 300, 16'h9999, 300);
        run_frame(16'h0001, 12'h100, -1, 16'h0000, 0);
        run_frame(16'h9876, 12'h945, -1, 16'h0000, 50);

        push_frame(16'h4321, 12'h111);
        ml_bcd   = 16'h4321;
        time_bcd = 12'h111;
        send     = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (699) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("midrst_queue", exp_q.size(), 0);
        check("midrst_idle", {busy, tx}, 2'b01);
        run_frame(16'h0420, 12'h045, -1, 16'h0000, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
